// File: rtl/ahb_lite_fir_accel_n.sv
// AHB-Lite FIR accelerator: NUM_TAPS coefficients and delay line, one shared MAC,
// saturating Q1.15 result with sticky overflow, result-valid and delay-line clear.
module ahb_lite_fir_accel_n #(
    parameter int NUM_TAPS = 8,
    parameter int ACC_W    = 36
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        hsel,
    input  logic [5:0]  haddr,
    input  logic        hsize,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [15:0] hwdata,
    output logic [15:0] hrdata,
    output logic        hresp
);
    // state | meaning
    // IDLE  | waiting for a SAMPLE write
    // MAC   | one tap per cycle: acc += x[tap] * coeff[tap]
    // DONE  | saturate acc >>> 15 into RESULT, set result_valid
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    state_t state, state_nxt;

    logic        dp_valid, dp_write, dp_size;
    logic [4:0]  dp_idx;

    logic signed [15:0]      coeff [NUM_TAPS];
    logic signed [15:0]      x     [NUM_TAPS];
    logic signed [ACC_W-1:0] acc;
    logic [TAP_W-1:0]        tap;
    logic [15:0]             result, last_sample;
    logic                    result_valid, overflow;

    logic is_status, is_result, is_sample, is_control, is_coeff, mapped;
    logic busy, err, wr_ok, start, coeff_we, clr_line, clr_ovf, result_rd;
    logic signed [15:0]      x_sel, c_sel;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] shifted;
    logic [15:0]             sat_val, rd_val;
    logic                    sat;

    // Bus decode; the register index ignores haddr[0] so byte accesses see the halfword.
    always_comb begin
        is_status  = (dp_idx == 5'd0);
        is_result  = (dp_idx == 5'd1);
        is_sample  = (dp_idx == 5'd2);
        is_control = (dp_idx == 5'd3);
        is_coeff   = dp_idx[4] && ({1'b0, dp_idx[3:0]} < 5'(NUM_TAPS));
        mapped     = is_status || is_result || is_sample || is_control || is_coeff;
        busy       = (state != IDLE);
        err        = dp_valid && (!mapped ||
                     (dp_write && (is_status || is_result || !dp_size ||
                                   ((is_sample || is_coeff) && busy))));
        wr_ok      = dp_valid && dp_write && !err;
        start      = wr_ok && is_sample;
        coeff_we   = wr_ok && is_coeff;
        clr_line   = wr_ok && is_control && hwdata[0] && !busy;
        clr_ovf    = wr_ok && is_control && hwdata[1] && !busy;
        result_rd  = dp_valid && !dp_write && is_result;
    end

    always_comb begin
        rd_val = '0;
        if (is_status)
            rd_val = {13'd0, overflow, result_valid, busy};
        else if (is_result)
            rd_val = result;
        else if (is_sample)
            rd_val = last_sample;
        else if (is_coeff)
            for (int k = 0; k < NUM_TAPS; k++)
                if (dp_idx[3:0] == 4'(k)) rd_val = coeff[k];
        hrdata = (dp_valid && !dp_write) ? rd_val : '0;
        hresp  = err;
    end

    always_comb begin
        x_sel = '0;
        c_sel = '0;
        for (int k = 0; k < NUM_TAPS; k++)
            if (tap == TAP_W'(k)) begin
                x_sel = x[k];
                c_sel = coeff[k];
            end
        prod    = 32'(x_sel) * 32'(c_sel);
        shifted = acc >>> 15;
        sat     = 1'b0;
        sat_val = shifted[15:0];
        if (shifted > SAT_MAX) begin
            sat     = 1'b1;
            sat_val = 16'h7FFF;
        end else if (shifted < SAT_MIN) begin
            sat     = 1'b1;
            sat_val = 16'h8000;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = MAC;
            MAC:  if (tap == TAP_W'(NUM_TAPS - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_valid     <= 1'b0;
            dp_write     <= 1'b0;
            dp_size      <= 1'b0;
            dp_idx       <= '0;
            acc          <= '0;
            tap          <= '0;
            result       <= '0;
            last_sample  <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                coeff[k] <= '0;
                x[k]     <= '0;
            end
        end else begin
            dp_valid <= hsel && (htrans == 2'b10);
            if (hsel && (htrans == 2'b10)) begin
                dp_write <= hwrite;
                dp_size  <= hsize;
                dp_idx   <= haddr[5:1];
            end

            for (int k = 0; k < NUM_TAPS; k++)
                if (coeff_we && (dp_idx[3:0] == 4'(k))) coeff[k] <= hwdata;

            if (start) begin
                x[0] <= hwdata;
                for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
                last_sample <= hwdata;
                acc         <= '0;
                tap         <= '0;
            end else if (clr_line) begin
                for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
            end

            if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                tap <= tap + 1'b1;
            end

            if (state == DONE) begin
                result <= sat_val;
                if (sat) overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            // DONE's set wins over a coincident RESULT read
            if (state == DONE)              result_valid <= 1'b1;
            else if (result_rd || clr_line) result_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ahb_lite_fir_accel_n.sv
// Directed bench for ahb_lite_fir_accel_n with NUM_TAPS = 4; expected RESULTs come
// from a behavioural filter model and are queued when each SAMPLE is written.
module tb_ahb_lite_fir_accel_n;
    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        hsel;
    logic [5:0]  haddr;
    logic        hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [15:0] hwdata;
    logic [15:0] hrdata;
    logic        hresp;

    ahb_lite_fir_accel_n #(.NUM_TAPS(NT), .ACC_W(36)) dut (
        .clk(clk), .n_rst(n_rst), .hsel(hsel), .haddr(haddr), .hsize(hsize),
        .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] rdata_s;
    logic        resp_s;
    logic [15:0] exp_q[$];
    logic [15:0] last_result = 16'h0000;
    int          m_c[NT];
    int          m_x[NT];
    logic        m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_c[i] = 0;
            m_x[i] = 0;
        end
        m_ovf = 1'b0;
    endtask

    task automatic model_sample(input logic [15:0] s);
        longint      sum, sh;
        logic [15:0] e;
        for (int i = NT - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = int'($signed(s));
        sum = 0;
        for (int i = 0; i < NT; i++) sum += longint'(m_x[i]) * longint'(m_c[i]);
        sh = sum >>> 15;
        if (sh > 32767) begin
            e = 16'h7FFF;
            m_ovf = 1'b1;
        end else if (sh < -32768) begin
            e = 16'h8000;
            m_ovf = 1'b1;
        end else begin
            e = sh[15:0];
        end
        exp_q.push_back(e);
    endtask

    // One bus cycle: drive an address phase plus the data-phase hwdata, sample mid-cycle.
    task automatic step(input logic av, input logic aw, input logic asz,
                        input logic [5:0] aa, input logic [15:0] wd);
        hsel   = av;
        htrans = av ? 2'b10 : 2'b00;
        hwrite = aw;
        hsize  = asz;
        haddr  = aa;
        hwdata = wd;
        @(negedge clk);
        rdata_s = hrdata;
        resp_s  = hresp;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic sz,
                      output logic r);
        step(1'b1, 1'b1, sz, a, 16'h0);
        step(1'b0, 1'b0, 1'b1, 6'h0, d);
        r = resp_s;
    endtask

    task automatic rd(input logic [5:0] a, input logic sz, output logic [15:0] d,
                      output logic r);
        step(1'b1, 1'b0, sz, a, 16'h0);
        step(1'b0, 1'b0, 1'b1, 6'h0, 16'h0);
        d = rdata_s;
        r = resp_s;
    endtask

    task automatic wr_coeff(input int k, input logic [15:0] d);
        logic r;
        wr(6'(32 + 2 * k), d, 1'b1, r);
        chk($sformatf("coeff%0d_wr_resp", k), r, 0);
        m_c[k] = int'($signed(d));
    endtask

    task automatic wait_idle();
        logic [15:0] d;
        logic        r;
        d = 16'h0001;
        for (int n = 0; n < 40 && d[0]; n++) rd(6'h00, 1'b1, d, r);
        chk("idle_within_budget", d[0], 0);
    endtask

    task automatic check_result(input string tag);
        logic [15:0] d, e;
        logic        r;
        rd(6'h02, 1'b1, d, r);
        chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            last_result = e;
            chk(tag, d, e);
        end
    endtask

    // SAMPLE write followed by STATUS reads in every following data phase.
    task automatic busy_profile(input logic [15:0] s);
        model_sample(s);
        step(1'b1, 1'b1, 1'b1, 6'h04, 16'h0);
        step(1'b1, 1'b0, 1'b1, 6'h00, s);
        chk("sample_wr_resp", resp_s, 0);
        for (int i = 1; i <= NT + 3; i++) begin
            step(i < NT + 3, 1'b0, 1'b1, 6'h00, 16'h0);
            chk($sformatf("busy_D+%0d", i), rdata_s[0], (i <= NT + 1) ? 1 : 0);
            if (i >= NT + 2) chk($sformatf("valid_D+%0d", i), rdata_s[1], 1);
        end
    endtask

    initial begin
        logic [15:0] d;
        logic        r;

        n_rst = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 1'b1; haddr = '0; hwdata = '0;
        model_reset();
        #1;
        chk("rst_hrdata", hrdata, 0);
        chk("rst_hresp", hresp, 0);
        #20;
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        for (int a = 0; a < 8; a += 2) begin
            rd(6'(a), 1'b1, d, r);
            chk($sformatf("rst_reg%0h_data", a), d, 0);
            chk($sformatf("rst_reg%0h_resp", a), r, 0);
        end
        for (int k = 0; k < NT; k++) begin
            rd(6'(32 + 2 * k), 1'b1, d, r);
            chk($sformatf("rst_coeff%0d_data", k), d, 0);
            chk($sformatf("rst_coeff%0d_resp", k), r, 0);
        end
        rd(6'(32 + 2 * NT), 1'b1, d, r);
        chk("coeff_oob_resp", r, 1);
        chk("coeff_oob_data", d, 0);

        for (int k = 0; k < NT; k++) wr_coeff(k, 16'h4000);
        busy_profile(16'd100);
        rd(6'h00, 1'b1, d, r);
        chk("status_valid_held", d, 16'h0002);
        check_result("result_100");
        rd(6'h00, 1'b1, d, r);
        chk("status_valid_cleared", d, 16'h0000);
        busy_profile(16'd200);
        check_result("result_200");

        for (int k = 0; k < NT; k++) wr_coeff(k, 16'h7FFF);
        for (int n = 0; n < 4; n++) begin
            model_sample(16'h7FFF);
            wr(6'h04, 16'h7FFF, 1'b1, r);
            chk("sat_sample_resp", r, 0);
            wait_idle();
            check_result($sformatf("sat_result%0d", n));
        end
        rd(6'h00, 1'b1, d, r);
        chk("status_overflow", d, {13'd0, m_ovf, 2'b00});
        wr(6'h06, 16'h0002, 1'b1, r);
        chk("ctrl_clr_ovf_resp", r, 0);
        m_ovf = 1'b0;
        rd(6'h00, 1'b1, d, r);
        chk("status_ovf_cleared", d, 16'h0000);

        wr(6'h06, 16'h0001, 1'b1, r);
        chk("ctrl_clr_line_resp", r, 0);
        for (int i = 0; i < NT; i++) m_x[i] = 0;
        wr_coeff(0, 16'h7FFF);
        wr_coeff(1, 16'hC000);
        wr_coeff(2, 16'h0000);
        wr_coeff(3, 16'h0000);
        model_sample(16'd1000);
        wr(6'h04, 16'd1000, 1'b1, r);
        chk("s1000_resp", r, 0);
        wr(6'h04, 16'd5, 1'b1, r);
        chk("busy_sample_err", r, 1);
        wr(6'h20, 16'h1234, 1'b1, r);
        chk("busy_coeff_err", r, 1);
        wait_idle();
        check_result("result_1000");
        rd(6'h20, 1'b1, d, r);
        chk("coeff0_kept", d, 16'h7FFF);
        rd(6'h21, 1'b0, d, r);
        chk("byte_read_coeff0", d, 16'h7FFF);
        rd(6'h04, 1'b1, d, r);
        chk("sample_readback", d, 16'd1000);
        model_sample(16'hFC18);
        wr(6'h04, 16'hFC18, 1'b1, r);
        wait_idle();
        check_result("result_m1000");

        wr(6'h02, 16'h5555, 1'b1, r);
        chk("wr_result_err", r, 1);
        wr(6'h22, 16'h1111, 1'b0, r);
        chk("wr_byte_err", r, 1);
        wr(6'h08, 16'h2222, 1'b1, r);
        chk("wr_unmapped_err", r, 1);
        rd(6'h02, 1'b1, d, r);
        chk("result_unchanged", d, last_result);
        rd(6'h22, 1'b1, d, r);
        chk("coeff1_unchanged", d, 16'hC000);

        wr(6'h04, 16'd300, 1'b1, r);
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_hresp", hresp, 0);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rd(6'h00, 1'b1, d, r);
        chk("midrst_status", d, 16'h0000);
        rd(6'h02, 1'b1, d, r);
        chk("midrst_result", d, 16'h0000);
        rd(6'h20, 1'b1, d, r);
        chk("midrst_coeff0", d, 16'h0000);
        model_sample(16'd77);
        wr(6'h04, 16'd77, 1'b1, r);
        wait_idle();
        check_result("post_rst_result");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
